stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 86 ++++++++
 tb/tb_stream_mux_rr.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with valid/ready on every port.
// Picks a channel either explicitly by sel or by round-robin from a rotating pointer.
module stream_mux_rr #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = 1,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [CH_W-1:0]         sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch
);

  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  grant;
  logic [WIDTH-1:0] grant_data;
  logic             found;
  logic             load;

  function automatic int wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    if (sum >= N_CH) sum = sum - N_CH;
    return sum;
  endfunction

  assign load = !out_valid || out_ready;

  // Round-robin scans from the highest offset down so the nearest valid channel to ptr wins.
  always_comb begin
    found      = 1'b0;
    grant      = '0;
    grant_data = '0;
    if (MODE == 0) begin
      for (int i = 0; i < N_CH; i++) begin
        if (sel == CH_W'(i) && in_valid[i]) begin
          found = 1'b1;
          grant = CH_W'(i);
        end
      end
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        if (in_valid[wrap_idx(int'(ptr), k)]) begin
          found = 1'b1;
          grant = CH_W'(wrap_idx(int'(ptr), k));
        end
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (grant == CH_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = !rst && load && found && (grant == CH_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant;
        ptr       <= (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised and directed bench for stream_mux_rr: a round-robin instance (4 ch)
// and an explicit-select instance (3 ch), both checked against a behavioural model.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  in_valid4 = '0;
  logic [3:0]  in_ready4;
  logic [31:0] in_data4 = '0;
  logic [1:0]  sel4 = '0;
  logic        out_valid4;
  logic        out_ready4 = 1'b1;
  logic [7:0]  out_data4;
  logic [1:0]  out_ch4;

  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic [23:0] in_data3 = '0;
  logic [1:0]  sel3 = '0;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    int         ch;
    int         ptr;
  } model_t;

  model_t m4 = '{v: 1'b0, d: 8'h00, ch: 0, ptr: 0};
  model_t m3 = '{v: 1'b0, d: 8'h00, ch: 0, ptr: 0};

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .sel(sel4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4), .out_ch(out_ch4)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(8), .MODE(0)) dut_sel (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .sel(sel3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3), .out_ch(out_ch3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Channel choice from the rules: explicit index, or first valid in ptr, ptr+1, ... wrapping.
  function automatic void pick(input int mode, input int n, input int ptr, input int sel,
                               input logic [15:0] valid, output bit found, output int grant);
    found = 0;
    grant = 0;
    if (mode == 0) begin
      if (sel < n && valid[sel]) begin
        found = 1;
        grant = sel;
      end
    end else begin
      for (int off = 0; off < n; off++) begin
        if (!found && valid[(ptr + off) % n]) begin
          found = 1;
          grant = (ptr + off) % n;
        end
      end
    end
  endfunction

  function automatic void advance(inout model_t m, input bit do_rst, input bit load, input bit found,
                                  input int grant, input logic [7:0] data, input int n);
    if (do_rst) begin
      m = '{v: 1'b0, d: 8'h00, ch: 0, ptr: 0};
    end else if (load) begin
      if (found) begin
        m.v = 1'b1;
        m.d = data;
        m.ch = grant;
        m.ptr = (grant + 1) % n;
      end else begin
        m.v = 1'b0;
      end
    end
  endfunction

  // One clock cycle: check combinational and registered outputs, then advance the model on the edge.
  task automatic applyStimulus();
    bit f4, f3, l4, l3;
    int g4, g3;
    logic [3:0] er4;
    logic [2:0] er3;
    #1;
    pick(1, 4, m4.ptr, int'(sel4), {12'h0, in_valid4}, f4, g4);
    pick(0, 3, m3.ptr, int'(sel3), {13'h0, in_valid3}, f3, g3);
    l4 = !m4.v || out_ready4;
    l3 = !m3.v || out_ready3;
    er4 = (!rst && l4 && f4) ? 4'(1 << g4) : 4'b0;
    er3 = (!rst && l3 && f3) ? 3'(1 << g3) : 3'b0;
    checkOutput("rr_in_ready", 32'(in_ready4), 32'(er4));
    checkOutput("rr_out_valid", 32'(out_valid4), 32'(m4.v));
    checkOutput("rr_out_data", 32'(out_data4), 32'(m4.d));
    checkOutput("rr_out_ch", 32'(out_ch4), 32'(m4.ch));
    checkOutput("sel_in_ready", 32'(in_ready3), 32'(er3));
    checkOutput("sel_out_valid", 32'(out_valid3), 32'(m3.v));
    checkOutput("sel_out_data", 32'(out_data3), 32'(m3.d));
    checkOutput("sel_out_ch", 32'(out_ch3), 32'(m3.ch));
    @(posedge clk);
    advance(m4, rst, l4, f4, g4, in_data4[g4*8 +: 8], 4);
    advance(m3, rst, l3, f3, g3, in_data3[g3*8 +: 8], 3);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);

    rst = 1'b1;
    in_valid4 = 4'hF;
    in_valid3 = 3'b111;
    in_data4 = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput("reset_in_ready", 32'(in_ready4), 32'h0);
      checkOutput("reset_out_valid", 32'(out_valid4), 32'h0);
      applyStimulus();
    end

    rst = 1'b0;
    in_valid3 = 3'b000;
    #1;
    checkOutput("first_grant", 32'(in_ready4), 32'h1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      #1;
      checkOutput("rr_seq_ch", 32'(out_ch4), 32'(i % 4));
      checkOutput("rr_seq_data", 32'(out_data4), 32'(8'h10 + 8'h11 * (i % 4)));
      checkOutput("rr_seq_valid", 32'(out_valid4), 32'h1);
    end

    in_valid4 = 4'b0010;
    applyStimulus();
    in_valid4 = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      #1;
      checkOutput("skip_wrap_ch", 32'(out_ch4), (i == 1) ? 32'd0 : 32'd3);
    end

    in_valid4 = 4'b0010;
    in_data4 = {8'h44, 8'h33, 8'h5A, 8'h11};
    applyStimulus();
    out_ready4 = 1'b0;
    in_valid4 = 4'hF;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      #1;
      checkOutput("bp_data", 32'(out_data4), 32'h5A);
      checkOutput("bp_ch", 32'(out_ch4), 32'h1);
      checkOutput("bp_in_ready", 32'(in_ready4), 32'h0);
    end
    out_ready4 = 1'b1;
    applyStimulus();
    #1;
    checkOutput("bp_refill_ch", 32'(out_ch4), 32'h2);
    checkOutput("bp_refill_data", 32'(out_data4), 32'h33);

    out_ready3 = 1'b1;
    in_valid3 = 3'b011;
    in_data3 = {8'hC2, 8'hB1, 8'hA0};
    sel3 = 2'd1;
    applyStimulus();
    sel3 = 2'd2;
    #1;
    checkOutput("sel2_no_grant", 32'(in_ready3), 32'h0);
    applyStimulus();
    #1;
    checkOutput("sel2_valid_drop", 32'(out_valid3), 32'h0);
    sel3 = 2'd1;
    #1;
    checkOutput("sel1_grant", 32'(in_ready3), 32'h2);
    applyStimulus();
    #1;
    checkOutput("sel1_data", 32'(out_data3), 32'hB1);
    sel3 = 2'd3;
    #1;
    checkOutput("sel3_no_grant", 32'(in_ready3), 32'h0);
    applyStimulus();

    out_ready4 = 1'b0;
    in_valid4 = 4'hF;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    #1;
    checkOutput("midrst_valid", 32'(out_valid4), 32'h0);
    rst = 1'b0;
    out_ready4 = 1'b1;
    in_valid4 = 4'b1100;
    applyStimulus();
    #1;
    checkOutput("midrst_ptr_ch", 32'(out_ch4), 32'h2);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      in_valid4 = 4'($urandom);
      in_data4 = $urandom;
      out_ready4 = ($urandom_range(0, 3) != 0);
      in_valid3 = 3'($urandom);
      in_data3 = 24'($urandom);
      out_ready3 = ($urandom_range(0, 3) != 0);
      sel3 = 2'($urandom_range(0, 3));
      sel4 = 2'($urandom_range(0, 3));
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
